sic_exec_lsq: RTL and testbench

SIC_EXEC_LSQ -- requirements
Module: sic_exec_lsq

---
 rtl/sic_exec_lsq_if.sv | 64 ++++++
 rtl/sic_exec_lsq.sv | 208 ++++++++++++++++++++
 tb/tb_sic_exec_lsq.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sic_exec_lsq_if.sv
// Bundle of all packet, operand, ECR, memory, commit and exception signals of sic_exec_lsq.
// The master side is the surrounding pipeline/memory; the slave side is the LSQ itself.
interface sic_exec_lsq_if #(
  parameter int DEPTH    = 2,
  parameter int ID_WIDTH = 4,
  parameter int ECR_ID_W = 1
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                pkt_valid;
  logic [ID_WIDTH-1:0] pkt_issue_id;
  logic                pkt_mem_read;
  logic                pkt_mem_write;
  logic                pkt_write_gpr;
  logic [1:0]          pkt_size;
  logic                pkt_unsigned;
  logic [31:0]         pkt_imm;
  logic                pkt_read_rs;
  logic                pkt_read_rt;
  logic                pkt_dep_ecr_valid;
  logic [ECR_ID_W-1:0] pkt_dep_ecr_id;
  logic                req_instr;
  logic                rs_valid;
  logic                rt_valid;
  logic [31:0]         rs_rdata;
  logic [31:0]         rt_rdata;
  logic                ecr_read_en;
  logic [ECR_ID_W-1:0] ecr_read_addr;
  logic [1:0]          ecr_read_data;
  logic                mem_req;
  logic [ID_WIDTH-1:0] mem_req_issue_id;
  logic [29:0]         mem_addr;
  logic [3:0]          mem_be;
  logic [31:0]         mem_wdata;
  logic                mem_wen;
  logic                mem_grant;
  logic [31:0]         mem_rdata;
  logic                mem_release_lock;
  logic                reg_wcommit;
  logic [ID_WIDTH-1:0] reg_issue_id;
  logic [31:0]         reg_wdata;
  logic                exc_valid;
  logic [ID_WIDTH-1:0] exc_issue_id;
  logic [31:0]         exc_badaddr;
  logic [CNT_W-1:0]    q_count;

  modport master (
    output pkt_valid, pkt_issue_id, pkt_mem_read, pkt_mem_write, pkt_write_gpr, pkt_size,
           pkt_unsigned, pkt_imm, pkt_read_rs, pkt_read_rt, pkt_dep_ecr_valid, pkt_dep_ecr_id,
           rs_valid, rt_valid, rs_rdata, rt_rdata, ecr_read_data, mem_grant, mem_rdata,
    input  req_instr, ecr_read_en, ecr_read_addr, mem_req, mem_req_issue_id, mem_addr, mem_be,
           mem_wdata, mem_wen, mem_release_lock, reg_wcommit, reg_issue_id, reg_wdata,
           exc_valid, exc_issue_id, exc_badaddr, q_count
  );

  modport slave (
    input  pkt_valid, pkt_issue_id, pkt_mem_read, pkt_mem_write, pkt_write_gpr, pkt_size,
           pkt_unsigned, pkt_imm, pkt_read_rs, pkt_read_rt, pkt_dep_ecr_valid, pkt_dep_ecr_id,
           rs_valid, rt_valid, rs_rdata, rt_rdata, ecr_read_data, mem_grant, mem_rdata,
    output req_instr, ecr_read_en, ecr_read_addr, mem_req, mem_req_issue_id, mem_addr, mem_be,
           mem_wdata, mem_wen, mem_release_lock, reg_wcommit, reg_issue_id, reg_wdata,
           exc_valid, exc_issue_id, exc_badaddr, q_count
  );
endinterface

// File: rtl/sic_exec_lsq.sv
// Load/store execute stage: one AGU slot waiting on operands/ECR, feeding an in-order
// grant queue that issues word-addressed memory requests and commits load results.
module sic_exec_lsq #(
  parameter int DEPTH    = 2,
  parameter int ID_WIDTH = 4,
  parameter int ECR_ID_W = 1
) (
  input logic clk,
  input logic rst,
  sic_exec_lsq_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_OPND = 1'b1} agu_state_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                rd;
    logic                wr;
    logic                wgpr;
    logic [1:0]          size;
    logic                uns;
    logic [31:0]         imm;
    logic                read_rs;
    logic                read_rt;
    logic                dep_v;
    logic [ECR_ID_W-1:0] dep_id;
  } slot_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [29:0]         waddr;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [1:0]          lane;
    logic [1:0]          size;
    logic                uns;
    logic                rd;
    logic                wr;
    logic                wgpr;
  } entry_t;

  agu_state_e          state_q, state_d;
  slot_t               slot_q, slot_d;
  entry_t              entries_q [DEPTH];
  entry_t              entries_d [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                exc_valid_q, exc_valid_d;
  logic [ID_WIDTH-1:0] exc_id_q, exc_id_d;
  logic [31:0]         exc_addr_q, exc_addr_d;

  logic        busy_s, ecr_en_s, rf_ok_s, ecr_ok_s, abort_s, go_s, bad_s;
  logic        full_s, deq_s, enq_s, take_exc_s, mem_req_s, commit_s;
  logic [31:0] addr_s, ld_data_s;
  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;
  entry_t      new_entry_s, head_s;

  // AGU slot decision: abort beats exception beats enqueue; anything else stalls.
  always_comb begin
    busy_s    = (state_q == WAIT_OPND);
    ecr_en_s  = busy_s && slot_q.dep_v && !rst;
    rf_ok_s   = (!slot_q.read_rs || bus.rs_valid) && (!slot_q.read_rt || bus.rt_valid);
    ecr_ok_s  = !slot_q.dep_v || (bus.ecr_read_data == 2'b01);
    abort_s   = ecr_en_s && (bus.ecr_read_data == 2'b10);
    addr_s    = bus.rs_rdata + slot_q.imm;
    bad_s     = (slot_q.size == 2'd3) ||
                ((slot_q.size == 2'd1) && addr_s[0]) ||
                ((slot_q.size == 2'd2) && (addr_s[1:0] != 2'b00));
    full_s    = (count_q == CNT_W'(DEPTH));
    mem_req_s = (count_q != {CNT_W{1'b0}}) && !rst;
    deq_s     = mem_req_s && bus.mem_grant;
    go_s      = busy_s && !rst && !abort_s && rf_ok_s && ecr_ok_s;
    take_exc_s = go_s && bad_s;
    enq_s     = go_s && !bad_s && (!full_s || deq_s);

    new_entry_s       = '0;
    new_entry_s.id    = slot_q.id;
    new_entry_s.waddr = addr_s[31:2];
    new_entry_s.lane  = addr_s[1:0];
    new_entry_s.size  = slot_q.size;
    new_entry_s.uns   = slot_q.uns;
    new_entry_s.rd    = slot_q.rd;
    new_entry_s.wr    = slot_q.wr;
    new_entry_s.wgpr  = slot_q.wgpr;
    case (slot_q.size)
      2'd0: begin
        new_entry_s.be    = 4'b0001 << addr_s[1:0];
        new_entry_s.wdata = {4{bus.rt_rdata[7:0]}};
      end
      2'd1: begin
        new_entry_s.be    = addr_s[1] ? 4'b1100 : 4'b0011;
        new_entry_s.wdata = {2{bus.rt_rdata[15:0]}};
      end
      default: begin
        new_entry_s.be    = 4'b1111;
        new_entry_s.wdata = bus.rt_rdata;
      end
    endcase

    slot_d = slot_q;
    case (state_q)
      IDLE: begin
        if (bus.pkt_valid) begin
          state_d        = WAIT_OPND;
          slot_d.id      = bus.pkt_issue_id;
          slot_d.rd      = bus.pkt_mem_read;
          slot_d.wr      = bus.pkt_mem_write;
          slot_d.wgpr    = bus.pkt_write_gpr;
          slot_d.size    = bus.pkt_size;
          slot_d.uns     = bus.pkt_unsigned;
          slot_d.imm     = bus.pkt_imm;
          slot_d.read_rs = bus.pkt_read_rs;
          slot_d.read_rt = bus.pkt_read_rt;
          slot_d.dep_v   = bus.pkt_dep_ecr_valid;
          slot_d.dep_id  = bus.pkt_dep_ecr_id;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_OPND: begin
        if (abort_s || take_exc_s || enq_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_OPND;
        end
      end
      default: state_d = IDLE;
    endcase

    exc_valid_d = take_exc_s;
    exc_id_d    = take_exc_s ? slot_q.id : {ID_WIDTH{1'b0}};
    exc_addr_d  = take_exc_s ? addr_s : 32'd0;
  end

  // Grant queue bookkeeping; an enqueued entry is only visible at the head next cycle.
  always_comb begin
    entries_d = entries_q;
    if (enq_s) begin
      entries_d[tail_q] = new_entry_s;
    end else begin
      entries_d[tail_q] = entries_q[tail_q];
    end
    tail_d  = tail_q + PTR_W'(enq_s);
    head_d  = head_q + PTR_W'(deq_s);
    count_d = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
  end

  // Head-entry load data extraction by lane and extension mode.
  always_comb begin
    head_s    = entries_q[head_q];
    commit_s  = deq_s && head_s.rd && head_s.wgpr;
    ld_byte_s = bus.mem_rdata[{head_s.lane, 3'b000} +: 8];
    ld_half_s = head_s.lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (head_s.size)
      2'd0:    ld_data_s = head_s.uns ? {24'd0, ld_byte_s} : {{24{ld_byte_s[7]}}, ld_byte_s};
      2'd1:    ld_data_s = head_s.uns ? {16'd0, ld_half_s} : {{16{ld_half_s[15]}}, ld_half_s};
      default: ld_data_s = bus.mem_rdata;
    endcase
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      exc_valid_q <= 1'b0;
      exc_id_q    <= '0;
      exc_addr_q  <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      exc_valid_q <= exc_valid_d;
      exc_id_q    <= exc_id_d;
      exc_addr_q  <= exc_addr_d;
      entries_q   <= entries_d;
    end
  end

  assign bus.req_instr        = (!busy_s || rst) && !bus.pkt_valid;
  assign bus.ecr_read_en      = ecr_en_s;
  assign bus.ecr_read_addr    = ecr_en_s ? slot_q.dep_id : {ECR_ID_W{1'b0}};
  assign bus.mem_req          = mem_req_s;
  assign bus.mem_req_issue_id = mem_req_s ? head_s.id : {ID_WIDTH{1'b0}};
  assign bus.mem_addr         = mem_req_s ? head_s.waddr : 30'd0;
  assign bus.mem_be           = mem_req_s ? head_s.be : 4'd0;
  assign bus.mem_wdata        = mem_req_s ? head_s.wdata : 32'd0;
  assign bus.mem_wen          = deq_s && head_s.wr;
  assign bus.mem_release_lock = deq_s;
  assign bus.reg_wcommit      = commit_s;
  assign bus.reg_issue_id     = commit_s ? head_s.id : {ID_WIDTH{1'b0}};
  assign bus.reg_wdata        = commit_s ? ld_data_s : 32'd0;
  assign bus.exc_valid        = exc_valid_q && !rst;
  assign bus.exc_issue_id     = rst ? {ID_WIDTH{1'b0}} : exc_id_q;
  assign bus.exc_badaddr      = rst ? 32'd0 : exc_addr_q;
  assign bus.q_count          = rst ? {CNT_W{1'b0}} : count_q;
endmodule

// File: tb/tb_sic_exec_lsq.sv
// Randomized bench for sic_exec_lsq against a queue-based behavioural model, plus
// directed scenarios with hand-computed literal expectations.
module tb_sic_exec_lsq;
  localparam int DEPTH = 2;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          uns, rd, wr, wg;
    logic [31:0] rt;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sic_exec_lsq_if #(.DEPTH(DEPTH), .ID_WIDTH(4), .ECR_ID_W(1)) bus ();
  sic_exec_lsq #(.DEPTH(DEPTH), .ID_WIDTH(4), .ECR_ID_W(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_checks = 0;
  int n_errors = 0;

  // model state: pending slot packet, queue of accepted ops, pending exception
  bit          m_busy;
  logic [3:0]  m_id;
  bit          m_rd, m_wr, m_wg, m_uns, m_rrs, m_rrt, m_dv;
  logic [1:0]  m_size;
  logic [31:0] m_imm;
  logic        m_did;
  op_t         m_q[$];
  bit          m_exc;
  logic [3:0]  m_exc_id;
  logic [31:0] m_exc_addr;
  bit          d_leave, d_exc, d_enq, d_deq;
  op_t         d_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd0) return 4'(4'd1 << (a % 32'd4));
    if (size == 2'd1) return (a % 32'd4 == 32'd2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] rt);
    if (size == 2'd0) return (rt & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (rt & 32'hFFFF) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] exp_load(input op_t op, input logic [31:0] rdata);
    logic [31:0] v;
    if (op.size == 2'd0) begin
      v = (rdata >> (8 * (op.addr % 32'd4))) & 32'hFF;
      if (!op.uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (op.size == 2'd1) begin
      v = (rdata >> (16 * ((op.addr % 32'd4) / 32'd2))) & 32'hFFFF;
      if (!op.uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // compare all DUT outputs against the model for the current inputs and decide next step
  task automatic settle();
    bit rf_ok, ecr_ok, misal, has_head;
    logic [31:0] a;
    op_t head;
    #1;
    d_leave = 0; d_exc = 0; d_enq = 0; d_deq = 0;
    if (rst) begin
      chk("rst_req_instr", bus.req_instr, 32'(!bus.pkt_valid));
      chk("rst_mem_req", bus.mem_req, 32'd0);
      chk("rst_wcommit", bus.reg_wcommit, 32'd0);
      chk("rst_wen", bus.mem_wen, 32'd0);
      chk("rst_lock", bus.mem_release_lock, 32'd0);
      chk("rst_exc", bus.exc_valid, 32'd0);
      chk("rst_ecr_en", bus.ecr_read_en, 32'd0);
      chk("rst_q_count", bus.q_count, 32'd0);
      return;
    end
    has_head = (m_q.size() > 0);
    if (has_head) head = m_q[0];
    chk("req_instr", bus.req_instr, 32'(!m_busy && !bus.pkt_valid));
    chk("ecr_read_en", bus.ecr_read_en, 32'(m_busy && m_dv));
    if (m_busy && m_dv) chk("ecr_read_addr", bus.ecr_read_addr, 32'(m_did));
    chk("q_count", bus.q_count, m_q.size());
    chk("mem_req", bus.mem_req, 32'(has_head));
    d_deq = has_head && bus.mem_grant;
    if (has_head) begin
      chk("mem_addr", bus.mem_addr, head.addr / 32'd4);
      chk("mem_be", bus.mem_be, 32'(exp_be(head.size, head.addr)));
      chk("mem_wdata", bus.mem_wdata, exp_wdata(head.size, head.rt));
      chk("mem_req_issue_id", bus.mem_req_issue_id, 32'(head.id));
    end
    chk("mem_wen", bus.mem_wen, 32'(d_deq && head.wr));
    chk("mem_release_lock", bus.mem_release_lock, 32'(d_deq));
    chk("reg_wcommit", bus.reg_wcommit, 32'(d_deq && head.rd && head.wg));
    if (d_deq && head.rd && head.wg) begin
      chk("reg_issue_id", bus.reg_issue_id, 32'(head.id));
      chk("reg_wdata", bus.reg_wdata, exp_load(head, bus.mem_rdata));
    end
    chk("exc_valid", bus.exc_valid, 32'(m_exc));
    if (m_exc) begin
      chk("exc_issue_id", bus.exc_issue_id, 32'(m_exc_id));
      chk("exc_badaddr", bus.exc_badaddr, m_exc_addr);
    end
    if (m_busy) begin
      rf_ok  = (!m_rrs || bus.rs_valid) && (!m_rrt || bus.rt_valid);
      ecr_ok = !m_dv || bus.ecr_read_data == 2'b01;
      a      = bus.rs_rdata + m_imm;
      misal  = (m_size == 2'd3) || (m_size == 2'd1 && a % 32'd2 != 0) ||
               (m_size == 2'd2 && a % 32'd4 != 0);
      if (m_dv && bus.ecr_read_data == 2'b10) begin
        d_leave = 1;
      end else if (rf_ok && ecr_ok) begin
        if (misal) begin
          d_exc = 1; d_leave = 1;
        end else if (m_q.size() < DEPTH || d_deq) begin
          d_enq = 1; d_leave = 1;
          d_op = '{id: m_id, addr: a, size: m_size, uns: m_uns, rd: m_rd, wr: m_wr,
                   wg: m_wg, rt: bus.rt_rdata};
        end
      end
      if (d_exc) begin
        m_exc_addr = a;
      end
    end
  endtask

  task automatic advance();
    bit latch;
    @(posedge clk);
    latch = !m_busy && bus.pkt_valid;
    if (rst) begin
      m_busy = 0; m_exc = 0; m_q.delete();
    end else begin
      if (d_deq) void'(m_q.pop_front());
      if (d_enq) m_q.push_back(d_op);
      m_exc = d_exc;
      m_exc_id = m_id;
      if (m_busy && d_leave) m_busy = 0;
      if (latch) begin
        m_busy = 1; m_id = bus.pkt_issue_id; m_rd = bus.pkt_mem_read; m_wr = bus.pkt_mem_write;
        m_wg = bus.pkt_write_gpr; m_size = bus.pkt_size; m_uns = bus.pkt_unsigned;
        m_imm = bus.pkt_imm; m_rrs = bus.pkt_read_rs; m_rrt = bus.pkt_read_rt;
        m_dv = bus.pkt_dep_ecr_valid; m_did = bus.pkt_dep_ecr_id;
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] id, input bit rd, input bit wr, input bit wg,
                       input logic [1:0] size, input logic [31:0] imm, input bit rrs,
                       input bit rrt, input bit dv, input logic did);
    bus.pkt_valid = 1'b1; bus.pkt_issue_id = id; bus.pkt_mem_read = rd;
    bus.pkt_mem_write = wr; bus.pkt_write_gpr = wg; bus.pkt_size = size;
    bus.pkt_unsigned = 1'b0; bus.pkt_imm = imm; bus.pkt_read_rs = rrs;
    bus.pkt_read_rt = rrt; bus.pkt_dep_ecr_valid = dv; bus.pkt_dep_ecr_id = did;
    settle(); advance();
    bus.pkt_valid = 1'b0;
  endtask

  task automatic cyc();
    settle(); advance();
  endtask

  initial begin
    int r;
    rst = 1'b1;
    bus.pkt_valid = 0; bus.pkt_issue_id = 0; bus.pkt_mem_read = 0; bus.pkt_mem_write = 0;
    bus.pkt_write_gpr = 0; bus.pkt_size = 0; bus.pkt_unsigned = 0; bus.pkt_imm = 0;
    bus.pkt_read_rs = 0; bus.pkt_read_rt = 0; bus.pkt_dep_ecr_valid = 0; bus.pkt_dep_ecr_id = 0;
    bus.rs_valid = 1; bus.rt_valid = 1; bus.rs_rdata = 0; bus.rt_rdata = 0;
    bus.ecr_read_data = 2'b01; bus.mem_grant = 0; bus.mem_rdata = 0;
    m_busy = 0; m_exc = 0;
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;

    // signed LH at 0x1002 from the upper half
    bus.rs_rdata = 32'h1000;
    issue(4'd1, 1, 0, 1, 2'd1, 32'd2, 1, 0, 0, 1'b0);
    cyc();
    bus.mem_grant = 1'b1; bus.mem_rdata = 32'h8001_0000;
    settle();
    chk("lh_mem_addr", bus.mem_addr, 32'h400);
    chk("lh_mem_be", bus.mem_be, 32'hC);
    chk("lh_commit", bus.reg_wcommit, 32'd1);
    chk("lh_wdata", bus.reg_wdata, 32'hFFFF_8001);
    advance();
    bus.mem_grant = 1'b0;

    // SB at 0x2003
    bus.rs_rdata = 32'h2003; bus.rt_rdata = 32'hAB;
    issue(4'd2, 0, 1, 0, 2'd0, 32'd0, 1, 1, 0, 1'b0);
    cyc();
    bus.mem_grant = 1'b1;
    settle();
    chk("sb_be", bus.mem_be, 32'h8);
    chk("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    chk("sb_wen", bus.mem_wen, 32'd1);
    chk("sb_lock", bus.mem_release_lock, 32'd1);
    chk("sb_no_commit", bus.reg_wcommit, 32'd0);
    advance();
    bus.mem_grant = 1'b0;

    // misaligned LW at 0x1002
    bus.rs_rdata = 32'h1000;
    issue(4'd3, 1, 0, 1, 2'd2, 32'd2, 1, 0, 0, 1'b0);
    cyc();
    settle();
    chk("lw_exc_valid", bus.exc_valid, 32'd1);
    chk("lw_exc_addr", bus.exc_badaddr, 32'h1002);
    chk("lw_exc_id", bus.exc_issue_id, 32'd3);
    chk("lw_exc_no_req", bus.mem_req, 32'd0);
    advance();
    settle();
    chk("lw_exc_one_cycle", bus.exc_valid, 32'd0);
    advance();

    // ECR pending three cycles then abort
    bus.ecr_read_data = 2'b00;
    issue(4'd9, 1, 0, 1, 2'd2, 32'd0, 1, 0, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ecr_en_wait", bus.ecr_read_en, 32'd1);
      chk("ecr_addr_wait", bus.ecr_read_addr, 32'd1);
      advance();
    end
    bus.ecr_read_data = 2'b10;
    cyc();
    bus.ecr_read_data = 2'b01;
    settle();
    chk("abort_req_instr", bus.req_instr, 32'd1);
    chk("abort_q_count", bus.q_count, 32'd0);
    chk("abort_no_req", bus.mem_req, 32'd0);
    advance();

    // fill the queue, hold the third op, then drain in order
    for (int i = 0; i < 3; i++) begin
      issue(4'(4 + i), 1, 0, 1, 2'd2, 32'd0, 1, 0, 0, 1'b0);
      cyc();
    end
    settle();
    chk("full_q_count", bus.q_count, 32'd2);
    chk("full_slot_busy", bus.req_instr, 32'd0);
    advance();
    bus.mem_grant = 1'b1; bus.mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("drain_commit", bus.reg_wcommit, 32'd1);
      chk("drain_order", bus.reg_issue_id, 32'(4 + i));
      advance();
    end
    bus.mem_grant = 1'b0;
    settle();
    chk("drain_q_count", bus.q_count, 32'd0);
    advance();

    // reset with a full queue under an active grant
    for (int i = 0; i < 2; i++) begin
      issue(4'(7 + i), 1, 0, 1, 2'd2, 32'd0, 1, 0, 0, 1'b0);
      cyc();
    end
    bus.mem_grant = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    chk("post_rst_q_count", bus.q_count, 32'd0);
    chk("post_rst_mem_req", bus.mem_req, 32'd0);
    chk("post_rst_commit", bus.reg_wcommit, 32'd0);
    advance();
    bus.mem_grant = 1'b0;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.pkt_valid = ($urandom_range(0, 2) == 0);
      bus.pkt_issue_id = 4'($urandom);
      bus.pkt_mem_read = ($urandom_range(0, 1) == 1);
      bus.pkt_mem_write = !bus.pkt_mem_read;
      bus.pkt_write_gpr = bus.pkt_mem_read && ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      bus.pkt_size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      bus.pkt_unsigned = ($urandom_range(0, 1) == 1);
      r = int'($urandom_range(0, 15));
      bus.pkt_imm = (r < 10) ? 32'(r * 4) - 32'd16 : 32'(r - 10);
      bus.pkt_read_rs = ($urandom_range(0, 3) != 0);
      bus.pkt_read_rt = ($urandom_range(0, 1) == 1);
      bus.pkt_dep_ecr_valid = ($urandom_range(0, 2) == 0);
      bus.pkt_dep_ecr_id = ($urandom_range(0, 1) == 1);
      bus.rs_valid = ($urandom_range(0, 3) != 0);
      bus.rt_valid = ($urandom_range(0, 3) != 0);
      bus.rs_rdata = $urandom & 32'hFFFF_FFFC;
      bus.rt_rdata = $urandom;
      r = int'($urandom_range(0, 9));
      bus.ecr_read_data = (r < 6) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      bus.mem_grant = ($urandom_range(0, 1) == 1);
      bus.mem_rdata = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
